instr_sequencer: RTL and testbench

//  Drives the single-cycle datapath automatically, replacing manual switch entry of instruction address and write enables.

---
 rtl/seq_pkg.sv | 5 +
 rtl/btn_sync_edge.sv | 29 ++
 rtl/instr_sequencer.sv | 93 +++++++++
 tb/tb_instr_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and synchroniser depth for the instruction sequencer.
package seq_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WRITE, ADVANCE, HALT} seq_state_t;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: synchronises an asynchronous level and emits a registered one-cycle rising-edge pulse.
module btn_sync_edge
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d, pulse_q, pulse_d;
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end
    assign pulse_out = pulse_q;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: steps instruction_A through program memory on step/tick triggers,
// issuing one-cycle register/memory write strobes from per-address masks.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int NUM_INSTR = 8,
    parameter int TICK_DIV = 25_000_000,
    parameter logic [2**ADDR_W-1:0] RF_WE_MASK = '0,
    parameter logic [2**ADDR_W-1:0] DM_WE_MASK = '0,
    parameter bit WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_btn,
    input  logic              run_en,
    output logic [ADDR_W-1:0] instruction_A,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(TICK_DIV);
    seq_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic reg_write_q, reg_write_d, mem_write_q, mem_write_d;
    logic busy_q, busy_d, done_q, done_d;
    logic step_pulse, tick_pulse, trigger, last;

    btn_sync_edge u_btn (
        .clk      (clk),
        .rst      (rst),
        .async_in (step_btn),
        .pulse_out(step_pulse)
    );

    assign tick_pulse = cnt_q == CNT_W'(TICK_DIV - 1);
    assign trigger    = step_pulse | (run_en & tick_pulse);
    assign last       = addr_q == ADDR_W'(NUM_INSTR - 1);

    always_comb begin
        cnt_d   = run_en ? (tick_pulse ? '0 : cnt_q + CNT_W'(1)) : '0;
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE:    state_d = trigger ? FETCH : IDLE;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = ADVANCE;
            ADVANCE: begin
                state_d = (last && !WRAP) ? HALT : IDLE;
                addr_d  = last ? (WRAP ? '0 : addr_q) : addr_q + ADDR_W'(1);
            end
            HALT: begin
                state_d = step_pulse ? IDLE : HALT;
                addr_d  = step_pulse ? '0 : addr_q;
            end
            default: state_d = IDLE;
        endcase
        // Outputs decode the next state so they are registered alongside it.
        reg_write_d = (state_d == WRITE) ? RF_WE_MASK[addr_d] : 1'b0;
        mem_write_d = (state_d == WRITE) ? DM_WE_MASK[addr_d] : 1'b0;
        busy_d      = (state_d != IDLE) && (state_d != HALT);
        done_d      = state_d == HALT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign instruction_A = addr_q;
    assign RegWrite      = reg_write_q;
    assign MemWrite      = mem_write_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: drives a wrapping and a halting sequencer with shared stimulus and
// compares both every cycle against a cycles-since-trigger reference model.
module tb_instr_sequencer;
    localparam int TD = 4;
    localparam int NI = 8;
    localparam logic [7:0] RF = 8'b0000_0101;
    localparam logic [7:0] DM = 8'b0000_0010;

    logic clk = 1'b0, rst = 1'b1, step_btn = 1'b0, run_en = 1'b0;
    logic [1:0][2:0] a_o;
    logic [1:0] rw_o, mw_o, busy_o, done_o;
    int checks = 0, failures = 0;
    int age[2], addr[2];
    bit halted[2];
    int run_len;
    logic [3:0] bh;
    bit pulse_cur;
    int reg_cnt, mem_cnt;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(3), .NUM_INSTR(NI), .TICK_DIV(TD), .RF_WE_MASK(RF),
                      .DM_WE_MASK(DM), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_en(run_en),
        .instruction_A(a_o[0]), .RegWrite(rw_o[0]), .MemWrite(mw_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    instr_sequencer #(.ADDR_W(3), .NUM_INSTR(NI), .TICK_DIV(TD), .RF_WE_MASK(RF),
                      .DM_WE_MASK(DM), .WRAP(1'b0)) dut_halt (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_en(run_en),
        .instruction_A(a_o[1]), .RegWrite(rw_o[1]), .MemWrite(mw_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            age[v] = 0;
            addr[v] = 0;
            halted[v] = 1'b0;
        end
        run_len = 0;
        bh = '0;
        pulse_cur = 1'b0;
    endtask

    // age counts cycles since an accepted trigger (0 = waiting); strobes fire at age 3.
    task automatic model_step();
        bit trig;
        trig = pulse_cur | (run_en && (run_len % TD == TD - 1));
        for (int v = 0; v < 2; v++) begin
            if (halted[v]) begin
                if (pulse_cur) begin
                    halted[v] = 1'b0;
                    addr[v] = 0;
                end
            end else if (age[v] == 0) begin
                if (trig) age[v] = 1;
            end else if (age[v] == 4) begin
                age[v] = 0;
                if (addr[v] == NI - 1) begin
                    if (v == 0) addr[v] = 0;
                    else halted[v] = 1'b1;
                end else addr[v] = addr[v] + 1;
            end else age[v] = age[v] + 1;
        end
        run_len = run_en ? run_len + 1 : 0;
        bh = {bh[2:0], step_btn};
        pulse_cur = bh[2] & ~bh[3];
    endtask

    task automatic check_all();
        for (int v = 0; v < 2; v++) begin
            check($sformatf("A%0d", v), 32'(a_o[v]), addr[v]);
            check($sformatf("RegWrite%0d", v), 32'(rw_o[v]), 32'(age[v] == 3 && RF[addr[v]]));
            check($sformatf("MemWrite%0d", v), 32'(mw_o[v]), 32'(age[v] == 3 && DM[addr[v]]));
            check($sformatf("busy%0d", v), 32'(busy_o[v]), 32'(age[v] != 0));
            check($sformatf("done%0d", v), 32'(done_o[v]), 32'(halted[v]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (rw_o[0]) reg_cnt++;
        if (mw_o[0]) mem_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press(input int hold, input int after);
        step_btn = 1'b1;
        run(hold);
        step_btn = 1'b0;
        run(after);
    endtask

    task automatic apply_reset();
        #2;
        step_btn = 1'b0;
        run_en = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_RegWrite", 32'(rw_o[0]), 0);
        check("rst_A", 32'(a_o[0]), 0);
        check("rst_busy", 32'(busy_o[0]), 0);
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        reg_cnt = 0;
        mem_cnt = 0;
    endtask

    initial begin
        int i;
        int hold;
        #1;
        apply_reset();

        press(2, 12);
        check("step_reg_cnt", reg_cnt, 1);
        check("step_mem_cnt", mem_cnt, 0);
        check("step_A", 32'(a_o[0]), 1);
        check("step_busy", 32'(busy_o[0]), 0);

        reg_cnt = 0;
        mem_cnt = 0;
        press(2, 12);
        check("store_reg_cnt", reg_cnt, 0);
        check("store_mem_cnt", mem_cnt, 1);
        check("store_A", 32'(a_o[0]), 2);

        // Third instruction writes the register file; pull reset in its WRITE cycle.
        step_btn = 1'b1;
        cycle();
        cycle();
        step_btn = 1'b0;
        i = 0;
        while (age[0] != 3 && i < 20) begin
            cycle();
            i++;
        end
        check("pre_rst_RegWrite", 32'(rw_o[0]), 1);
        check("pre_rst_A", 32'(a_o[0]), 2);
        apply_reset();
        run(3);
        check("post_rst_A", 32'(a_o[0]), 0);
        check("post_rst_busy", 32'(busy_o[0]), 0);
        check("post_rst_reg_cnt", reg_cnt, 0);

        run_en = 1'b1;
        i = 0;
        while (!done_o[1] && i < 200) begin
            cycle();
            i++;
        end
        check("halt_done", 32'(done_o[1]), 1);
        check("halt_A", 32'(a_o[1]), 7);
        check("wrap_A", 32'(a_o[0]), 0);
        check("pass_reg_cnt", reg_cnt, 2);
        check("pass_mem_cnt", mem_cnt, 1);
        run(20);
        check("halt_hold_A", 32'(a_o[1]), 7);
        check("halt_hold_done", 32'(done_o[1]), 1);
        run_en = 1'b0;
        press(2, 12);
        check("halt_exit_A", 32'(a_o[1]), 0);
        check("halt_exit_done", 32'(done_o[1]), 0);

        apply_reset();
        step_btn = 1'b1;
        cycle();
        step_btn = 1'b0;
        cycle();
        step_btn = 1'b1;
        run(3);
        step_btn = 1'b0;
        run(15);
        check("drop_A", 32'(a_o[0]), 1);
        check("drop_reg_cnt", reg_cnt, 1);

        hold = 0;
        for (int k = 0; k < 600; k++) begin
            if (hold == 0) begin
                step_btn = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) run_en = ~run_en;
                hold = $urandom_range(1, 6);
            end
            hold--;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
